nios2_mul_result_combiner: RTL and testbench
============================================

// Module: nios2_mul_result_combiner
// PURPOSE
//  Consumer side of the Nios II multiplier cell. Accepts the four registered
//  16x16 partial products for one multiply and combines them into the 64-bit
//  product. Returns the low word for MUL and the high word for MULXUU, MULXSU
//  and MULXSS. Two-stage valid/ready pipeline between the mult cell and the
//  writeback mux. Supports backpressure and a pipeline flush.
// PARAMETERS
//  DATA_W   32   operand width; must be even; HALF_W = DATA_W/2
//  OP_W     2    width of the op code
// PORTS
//  clk          in   1        system clock
//  reset_n      in   1        reset; synchronous, active-low
//  flush        in   1        kill all in-flight ops (pipeline flush/exception)
//  in_valid     in   1        partial-product set valid
//  in_ready     out  1        combiner can accept this cycle
//  in_op        in   OP_W     0=MUL 1=MULXUU 2=MULXSU 3=MULXSS
//  in_p1        in   DATA_W   a_lo*b_lo (unsigned x unsigned)
//  in_p2        in   DATA_W   a_lo*b_hi (b_hi signed iff op==MULXSS)
//  in_p3        in   DATA_W   a_hi*b_lo (a_hi signed iff op in {MULXSU,MULXSS})
//  in_p4        in   DATA_W   a_hi*b_hi (per-operand signedness as above)
//  out_valid    out  1        result valid
//  out_ready    in   1        downstream accepts result
//  out_result   out  DATA_W   selected word (low for MUL, high otherwise)
//  out_busy     out  1        any stage holds a valid op
// BEHAVIOUR
//  - Reset (reset_n=0 at clk edge): both stage valids=0, all data regs=0.
//    While reset_n=0: out_valid=0, out_result=0, out_busy=0, in_ready=0.
//  - Accept: in_valid & in_ready at an edge. Result is presented 2 cycles
//    later when there is no stall. Throughput is 1 op/cycle.
//  - Signedness is derived from op only: s1 = (op==MULXSU | op==MULXSS),
//    s2 = (op==MULXSS). MUL uses unsigned, because the low word is identical.
//  - Stage 1 registers the following:
//      mid = ext(p2,s2) + ext(p3,s1), DATA_W+2 bits, signed
//      p1, p4, op, valid
//    ext() is sign-extension if the flag is set, else zero-extension.
//  - Stage 2 computes full = {p4,p1} + (sext(mid) << HALF_W), 2*DATA_W bits,
//    modulo 2^(2*DATA_W). It registers out_result = op==MUL ? full[DATA_W-1:0]
//    : full[2*DATA_W-1:DATA_W].
//  - Advance rule: stage 2 loads when !out_valid | out_ready. Stage 1 loads
//    when stage 1 is empty or stage 2 loads.
//      in_ready = reset_n & !flush & (!s1_valid | s2_load)
//  - Output holds stable (data and valid) while out_valid & !out_ready.
//  - Ordering: results leave in acceptance order. No drop, no duplicate.
//  - flush=1: at that edge both valids are cleared and no input is accepted.
//    A beat with out_valid & out_ready in the same cycle is completed
//    (consumed). Data regs need not be cleared.
//  - Reset asserted mid-operation behaves as flush plus clearing data to 0.
//  - out_busy = s1_valid | out_valid (combinational from the regs).
// STRUCTURE
//  - Package nios2_mul_pkg: op enum (MUL, MULXUU, MULXSU, MULXSS), DATA_W and
//    HALF_W localparams, functions op_src1_signed()/op_src2_signed().
//  - One sub-module, nios2_mul_pipe_reg: generic valid/ready register slice
//    with flush. Instantiate it twice, around the stage-1 and stage-2
//    arithmetic.
// TESTING
//  1 reset_n=0 for 3 cycles with in_valid=1 -> in_ready=0, out_valid=0,
//    out_result=0. Release reset -> in_ready=1 next cycle.
//  2 MULXUU: p1=p2=p3=p4=0xFFFE0001 (0xFFFFFFFF^2) -> out_result=0xFFFFFFFE
//    exactly 2 cycles after accept. Same inputs with MUL -> 0x00000001.
//  3 MULXSS: p1=0xFFFE0001, p2=p3=0xFFFF0001, p4=0x00000001 (-1*-1)
//    -> 0x00000000. MUL on these inputs -> 0x00000001.
//  4 MULXSU: p1=p2=0xFFFE0001, p3=p4=0xFFFF0001 (-1 * 0xFFFFFFFF)
//    -> 0xFFFFFFFF.
//  5 out_ready=0, present 3 ops back-to-back -> 2 accepted, then in_ready=0.
//    Raise out_ready -> 3 results in order, each held stable while stalled.
//  6 Two ops in flight, flush=1 for 1 cycle -> out_valid=0 next cycle,
//    out_busy=0. Next op (test 2) returns the correct value with latency 2.
//  Bench compares every beat against a 64-bit scoreboard model, with random
//  stall/flush.

Source files
------------

// File: rtl/nios2_mul_pkg.sv
// rtl/nios2_mul_pkg.sv - shared op codes, widths and signedness helpers for the multiply combiner
// Contents:
//   op_e              MUL / MULXUU / MULXSU / MULXSS op codes
//   DATA_W, HALF_W    default operand width and its half
//   op_src1_signed()  1 when operand A (src1) is treated as signed
//   op_src2_signed()  1 when operand B (src2) is treated as signed
package nios2_mul_pkg;

   localparam int DATA_W = 32;
   localparam int HALF_W = DATA_W / 2;

   typedef enum logic [1:0] {
      OP_MUL    = 2'd0,
      OP_MULXUU = 2'd1,
      OP_MULXSU = 2'd2,
      OP_MULXSS = 2'd3
   } op_e;

   // MUL is handled as unsigned: the low word does not depend on signedness.
   function automatic logic op_src1_signed(input op_e op);
      return (op == OP_MULXSU) || (op == OP_MULXSS);
   endfunction

   function automatic logic op_src2_signed(input op_e op);
      return (op == OP_MULXSS);
   endfunction

endpackage

// File: rtl/nios2_mul_result_combiner_if.sv
// rtl/nios2_mul_result_combiner_if.sv - partial-product input and result output bus of the combiner
// Signals:
//   in_valid/in_ready   partial-product handshake (master drives in_valid)
//   in_op               op code, see nios2_mul_pkg::op_e
//   in_p1..in_p4        partial products a_lo*b_lo, a_lo*b_hi, a_hi*b_lo, a_hi*b_hi
//   out_valid/out_ready result handshake (slave drives out_valid)
//   out_result          selected product word
//   out_busy            combiner holds at least one op
// Modports: master = mult cell / writeback side, slave = combiner.
interface nios2_mul_result_combiner_if #(
   parameter int DATA_W = nios2_mul_pkg::DATA_W,
   parameter int OP_W   = 2
);
   logic              in_valid;
   logic              in_ready;
   logic [OP_W-1:0]   in_op;
   logic [DATA_W-1:0] in_p1;
   logic [DATA_W-1:0] in_p2;
   logic [DATA_W-1:0] in_p3;
   logic [DATA_W-1:0] in_p4;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_result;
   logic              out_busy;

   modport master (
      output in_valid, in_op, in_p1, in_p2, in_p3, in_p4, out_ready,
      input  in_ready, out_valid, out_result, out_busy
   );

   modport slave (
      input  in_valid, in_op, in_p1, in_p2, in_p3, in_p4, out_ready,
      output in_ready, out_valid, out_result, out_busy
   );
endinterface

// File: rtl/nios2_mul_pipe_reg.sv
// rtl/nios2_mul_pipe_reg.sv - generic valid/ready register slice with flush
// Ports:
//   clk, reset_n                 clock, synchronous active-low reset (clears valid and data)
//   flush_i                      drop the held beat, accept nothing this edge
//   in_valid_i/in_ready_o/in_data_i    upstream side
//   out_valid_o/out_ready_i/out_data_o downstream side (forced to 0 while in reset)
module nios2_mul_pipe_reg #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         flush_i,
   input  logic         in_valid_i,
   output logic         in_ready_o,
   input  logic [W-1:0] in_data_i,
   output logic         out_valid_o,
   input  logic         out_ready_i,
   output logic [W-1:0] out_data_o
);

   logic         valid_q, valid_d;
   logic [W-1:0] data_q, data_d;
   logic         load;

   always_comb begin
      // The slot can take a new beat when empty or when its beat leaves this edge.
      load       = !valid_q || out_ready_i;
      in_ready_o = reset_n && !flush_i && load;
      valid_d    = valid_q;
      data_d     = data_q;
      if (flush_i) begin
         valid_d = 1'b0;
      end else if (load) begin
         valid_d = in_valid_i;
         if (in_valid_i) begin
            data_d = in_data_i;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   // Outputs read as idle while reset is held, even before the first edge.
   assign out_valid_o = valid_q && reset_n;
   assign out_data_o  = reset_n ? data_q : '0;

endmodule

// File: rtl/nios2_mul_result_combiner.sv
// rtl/nios2_mul_result_combiner.sv - combines four 16x16 partial products into the selected product word
// Ports:
//   clk, reset_n   clock, synchronous active-low reset
//   flush          kill all in-flight ops this edge
//   bus (slave)    partial-product input handshake, result output handshake, busy flag
// Stage 1 sums the two cross products, stage 2 forms the 64-bit product and
// selects the low word (MUL) or the high word (MULX*).
module nios2_mul_result_combiner #(
   parameter int DATA_W = nios2_mul_pkg::DATA_W,
   parameter int OP_W   = 2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic flush,
   nios2_mul_result_combiner_if.slave bus
);
   import nios2_mul_pkg::*;

   localparam int HALF  = DATA_W / 2;
   localparam int MID_W = DATA_W + 2;
   localparam int S1_W  = MID_W + 2 * DATA_W + OP_W;

   // ---------------- stage 1 arithmetic ----------------
   logic             sgn1, sgn2;
   logic [MID_W-1:0] mid_in;
   logic [S1_W-1:0]  s1_in_data;

   always_comb begin
      sgn1   = op_src1_signed(op_e'(bus.in_op[1:0]));
      sgn2   = op_src2_signed(op_e'(bus.in_op[1:0]));
      // p2 carries b_hi's sign, p3 carries a_hi's sign; two guard bits hold the sum.
      mid_in = {{2{sgn2 & bus.in_p2[DATA_W-1]}}, bus.in_p2}
             + {{2{sgn1 & bus.in_p3[DATA_W-1]}}, bus.in_p3};
      s1_in_data = {mid_in, bus.in_p4, bus.in_p1, bus.in_op};
   end

   logic            s1_valid;
   logic            s1_ready;
   logic [S1_W-1:0] s1_data;
   logic            s2_ready;

   nios2_mul_pipe_reg #(.W(S1_W)) u_stage1 (
      .clk         (clk),
      .reset_n     (reset_n),
      .flush_i     (flush),
      .in_valid_i  (bus.in_valid),
      .in_ready_o  (s1_ready),
      .in_data_i   (s1_in_data),
      .out_valid_o (s1_valid),
      .out_ready_i (s2_ready),
      .out_data_o  (s1_data)
   );

   // ---------------- stage 2 arithmetic ----------------
   logic [MID_W-1:0]    mid_q;
   logic [DATA_W-1:0]   p4_q, p1_q;
   logic [OP_W-1:0]     op_q;
   logic [2*DATA_W-1:0] mid_ext;
   logic [2*DATA_W-1:0] full;
   logic [DATA_W-1:0]   result_d;

   always_comb begin
      {mid_q, p4_q, p1_q, op_q} = s1_data;
      mid_ext  = {{(2*DATA_W-MID_W){mid_q[MID_W-1]}}, mid_q};
      // Wraps modulo 2^(2*DATA_W); the signed mid term supplies the borrows.
      full     = {p4_q, p1_q} + (mid_ext << HALF);
      result_d = (op_q[1:0] == OP_MUL) ? full[DATA_W-1:0] : full[2*DATA_W-1:DATA_W];
   end

   nios2_mul_pipe_reg #(.W(DATA_W)) u_stage2 (
      .clk         (clk),
      .reset_n     (reset_n),
      .flush_i     (flush),
      .in_valid_i  (s1_valid),
      .in_ready_o  (s2_ready),
      .in_data_i   (result_d),
      .out_valid_o (bus.out_valid),
      .out_ready_i (bus.out_ready),
      .out_data_o  (bus.out_result)
   );

   assign bus.in_ready = s1_ready;
   assign bus.out_busy = s1_valid | bus.out_valid;

endmodule

// File: tb/tb_nios2_mul_result_combiner.sv
// tb/tb_nios2_mul_result_combiner.sv - self-checking bench for nios2_mul_result_combiner
module tb_nios2_mul_result_combiner;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic flush = 1'b0;

   nios2_mul_result_combiner_if #(.DATA_W(32), .OP_W(2)) bus ();

   nios2_mul_result_combiner #(.DATA_W(32), .OP_W(2)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .flush   (flush),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // Reference: build partial products from operands and the expected word from
   // a plain 64-bit multiply of the operands with the op's signedness.
   task automatic gen(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      output logic [31:0] p1, output logic [31:0] p2,
                      output logic [31:0] p3, output logic [31:0] p4,
                      output logic [31:0] res);
      logic        sa, sb;
      longint      al, ah, bl, bh, aa, bb, t;
      logic [63:0] prod;
      sa = (op == 2'd2) || (op == 2'd3);
      sb = (op == 2'd3);
      al = longint'(a[15:0]);
      bl = longint'(b[15:0]);
      ah = sa ? longint'($signed(a[31:16])) : longint'(a[31:16]);
      bh = sb ? longint'($signed(b[31:16])) : longint'(b[31:16]);
      t  = al * bl; p1 = t[31:0];
      t  = al * bh; p2 = t[31:0];
      t  = ah * bl; p3 = t[31:0];
      t  = ah * bh; p4 = t[31:0];
      aa = sa ? longint'($signed(a)) : longint'({32'd0, a});
      bb = sb ? longint'($signed(b)) : longint'({32'd0, b});
      prod = aa * bb;
      res  = (op == 2'd0) ? prod[31:0] : prod[63:32];
   endtask

   task automatic drive_in(input logic [1:0] op, input logic [31:0] p1, input logic [31:0] p2,
                           input logic [31:0] p3, input logic [31:0] p4);
      bus.in_op = op;
      bus.in_p1 = p1;
      bus.in_p2 = p2;
      bus.in_p3 = p3;
      bus.in_p4 = p4;
      bus.in_valid = 1'b1;
   endtask

   // One op with out_ready high: accepted at the next edge, visible two negedges later.
   task automatic run_one(input string tag, input logic [1:0] op, input logic [31:0] p1,
                          input logic [31:0] p2, input logic [31:0] p3, input logic [31:0] p4,
                          input logic [31:0] exp);
      @(negedge clk);
      drive_in(op, p1, p2, p3, p4);
      bus.out_ready = 1'b1;
      #1 chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk({tag, "_lat1_valid"}, 64'(bus.out_valid), 64'd0);
      @(negedge clk);
      chk({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
      chk({tag, "_result"}, 64'(bus.out_result), 64'(exp));
   endtask

   logic [31:0] exp_q[$];

   initial begin
      logic [1:0]  op;
      logic [31:0] a, b, p1, p2, p3, p4, res, held, e;
      logic        hold_chk;

      bus.in_valid = 1'b0;
      bus.in_op = '0;
      bus.in_p1 = '0;
      bus.in_p2 = '0;
      bus.in_p3 = '0;
      bus.in_p4 = '0;
      bus.out_ready = 1'b0;

      // 1: reset with in_valid asserted
      drive_in(2'd1, 32'h1234_5678, 32'h1, 32'h2, 32'h3);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
         chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
         chk("rst_out_result", 64'(bus.out_result), 64'd0);
         chk("rst_busy", 64'(bus.out_busy), 64'd0);
      end
      bus.in_valid = 1'b0;
      reset_n = 1'b1;
      @(negedge clk);
      chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
      chk("post_rst_out_valid", 64'(bus.out_valid), 64'd0);

      // 2..4: directed arithmetic
      run_one("mulxuu_max", 2'd1, 32'hFFFE0001, 32'hFFFE0001, 32'hFFFE0001, 32'hFFFE0001, 32'hFFFFFFFE);
      run_one("mul_max", 2'd0, 32'hFFFE0001, 32'hFFFE0001, 32'hFFFE0001, 32'hFFFE0001, 32'h00000001);
      run_one("mulxss_m1", 2'd3, 32'hFFFE0001, 32'hFFFF0001, 32'hFFFF0001, 32'h00000001, 32'h00000000);
      run_one("mul_m1", 2'd0, 32'hFFFE0001, 32'hFFFF0001, 32'hFFFF0001, 32'h00000001, 32'h00000001);
      run_one("mulxsu", 2'd2, 32'hFFFE0001, 32'hFFFE0001, 32'hFFFF0001, 32'hFFFF0001, 32'hFFFFFFFF);

      // 5: backpressure, three ops back-to-back
      @(negedge clk);
      bus.out_ready = 1'b0;
      drive_in(2'd1, 32'hFFFE0001, 32'hFFFE0001, 32'hFFFE0001, 32'hFFFE0001);
      #1 chk("bp_acc_a", 64'(bus.in_ready), 64'd1);
      @(negedge clk);
      drive_in(2'd3, 32'hFFFE0001, 32'hFFFF0001, 32'hFFFF0001, 32'h00000001);
      #1 chk("bp_acc_b", 64'(bus.in_ready), 64'd1);
      @(negedge clk);
      drive_in(2'd2, 32'hFFFE0001, 32'hFFFE0001, 32'hFFFF0001, 32'hFFFF0001);
      #1 chk("bp_full", 64'(bus.in_ready), 64'd0);
      chk("bp_hold_a0", 64'(bus.out_result), 64'hFFFFFFFE);
      @(negedge clk);
      chk("bp_hold_v", 64'(bus.out_valid), 64'd1);
      chk("bp_hold_a1", 64'(bus.out_result), 64'hFFFFFFFE);
      @(negedge clk);
      bus.out_ready = 1'b1;
      #1 chk("bp_acc_c", 64'(bus.in_ready), 64'd1);
      chk("bp_res_a", 64'(bus.out_result), 64'hFFFFFFFE);
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk("bp_res_b_v", 64'(bus.out_valid), 64'd1);
      chk("bp_res_b", 64'(bus.out_result), 64'h00000000);
      @(negedge clk);
      chk("bp_res_c_v", 64'(bus.out_valid), 64'd1);
      chk("bp_res_c", 64'(bus.out_result), 64'hFFFFFFFF);
      @(negedge clk);
      chk("bp_empty", 64'(bus.out_valid), 64'd0);

      // 6: flush with two ops in flight
      bus.out_ready = 1'b0;
      drive_in(2'd1, 32'h1, 32'h2, 32'h3, 32'h4);
      @(negedge clk);
      drive_in(2'd0, 32'h5, 32'h6, 32'h7, 32'h8);
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk("fl_busy_before", 64'(bus.out_busy), 64'd1);
      flush = 1'b1;
      #1 chk("fl_in_ready", 64'(bus.in_ready), 64'd0);
      @(negedge clk);
      flush = 1'b0;
      chk("fl_out_valid", 64'(bus.out_valid), 64'd0);
      chk("fl_busy", 64'(bus.out_busy), 64'd0);
      run_one("fl_after", 2'd1, 32'hFFFE0001, 32'hFFFE0001, 32'hFFFE0001, 32'hFFFE0001, 32'hFFFFFFFE);

      // Random traffic against the scoreboard
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(negedge clk);
      hold_chk = 1'b0;
      held = '0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         if (hold_chk) begin
            chk("rnd_hold_valid", 64'(bus.out_valid), 64'd1);
            chk("rnd_hold_data", 64'(bus.out_result), 64'(held));
         end
         chk("rnd_busy", 64'(bus.out_busy), 64'(exp_q.size() != 0));
         op = 2'($urandom_range(0, 3));
         a  = $urandom;
         b  = $urandom;
         if ($urandom_range(0, 7) == 0) a = 32'hFFFFFFFF;
         if ($urandom_range(0, 7) == 0) b = 32'h80000000;
         gen(op, a, b, p1, p2, p3, p4, res);
         drive_in(op, p1, p2, p3, p4);
         bus.in_valid  = ($urandom_range(0, 99) < 70);
         bus.out_ready = ($urandom_range(0, 99) < 60);
         flush         = ($urandom_range(0, 99) < 3);
         #1;
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               chk("rnd_spurious", 64'd1, 64'd0);
            end else begin
               e = exp_q.pop_front();
               chk("rnd_beat", 64'(bus.out_result), 64'(e));
            end
         end
         if (bus.in_valid && bus.in_ready) exp_q.push_back(res);
         if (flush) begin
            exp_q.delete();
            chk("rnd_flush_ready", 64'(bus.in_ready), 64'd0);
         end
         hold_chk = bus.out_valid && !bus.out_ready && !flush;
         held     = bus.out_result;
      end

      // Drain remaining results
      @(negedge clk);
      flush = 1'b0;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      for (int c = 0; c < 8; c++) begin
         #1;
         if (bus.out_valid) begin
            if (exp_q.size() == 0) begin
               chk("drain_spurious", 64'd1, 64'd0);
            end else begin
               e = exp_q.pop_front();
               chk("drain_beat", 64'(bus.out_result), 64'(e));
            end
         end
         @(negedge clk);
      end
      chk("drain_missing", 64'(exp_q.size()), 64'd0);
      chk("drain_busy", 64'(bus.out_busy), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
